mul_err_sweep_ctrl: RTL and testbench
=====================================

MUL_ERR_SWEEP_CTRL -- requirements
Module: mul_err_sweep_ctrl

Interface
REQ-001 Parameter SETTLE, default 78: cycles allowed for the multiplier output to settle after operands change; legal range 1..1023.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  single-cycle request to begin a sweep.
REQ-005 num_samples  input  32  number of operand pairs to apply; sampled on accepted start.
REQ-006 seed  input  32  LFSR seed; sampled on accepted start.
REQ-007 mul_a, mul_b  output  16 each  operands driven to the multiplier under test.
REQ-008 mul_p  input  32  product returned by the multiplier under test.
REQ-009 busy  output  1  high from the cycle after accepted start until the cycle before done.
REQ-010 done  output  1  one-cycle pulse at sweep end.
REQ-011 err_count  output  32  samples where mul_p differs from the exact product.
REQ-012 sum_abs_ed  output  64  sum of |exact - mul_p| over the sweep.
REQ-013 max_abs_ed  output  32  largest |exact - mul_p| over the sweep.

Function
REQ-014 FSM states: IDLE, LOAD, SETTLE, CHECK, DONE.
REQ-015 In IDLE, start=1 is accepted: the block captures num_samples and seed, clears all three metric outputs and the sample index, and goes to DONE if num_samples==0, otherwise to LOAD.
REQ-016 start is ignored in every state other than IDLE.
REQ-017 The operand source is a 32-bit Galois LFSR with polynomial x^32+x^22+x^2+x+1 (mask 0x80200003); a zero seed is loaded as 0x00000001.
REQ-018 LOAD lasts 1 cycle: it registers mul_a=lfsr[31:16] and mul_b=lfsr[15:0], clears the settle counter, then goes to SETTLE.
REQ-019 SETTLE lasts exactly SETTLE cycles, then goes to CHECK.
REQ-020 CHECK lasts 1 cycle:
- samples mul_p and computes exact = mul_a*mul_b (unsigned, 32-bit);
- increments err_count if they differ;
- adds the absolute difference to sum_abs_ed, non-wrapping (worst case fits in 64 bits);
- advances the LFSR one step and increments the sample index;
- goes to DONE if the index reaches num_samples, otherwise to LOAD.
REQ-021 Each sample takes exactly SETTLE+2 cycles. done is high in cycle N*(SETTLE+2)+1 after the start edge, counting the start edge as cycle 0.
REQ-022 DONE lasts 1 cycle with done=1 and busy=0, then goes to IDLE.
REQ-023 Metric outputs hold their values after DONE until the next accepted start.
REQ-024 mul_a and mul_b hold their last value outside LOAD.

Reset
REQ-025 rst=1 in any state, including mid-sweep, forces IDLE on the next edge: busy=0, done=0, mul_a=mul_b=0, err_count=sum_abs_ed=max_abs_ed=0, LFSR=0x00000001, settle counter and sample index 0.
REQ-026 rst takes priority over start in the same cycle.

Configuration
REQ-027 Macro MUL_ERR_MAX_TRACK_EN:
- defined: CHECK updates max_abs_ed with the running maximum of the absolute difference;
- undefined: the max comparator and register are omitted, and max_abs_ed is constant 0.

Verification
REQ-028 SETTLE=2, exact behavioural multiplier, seed=0x12345678, num_samples=3, start pulse -> done at cycle 13, busy high cycles 1-12, err_count=0, sum_abs_ed=0, max_abs_ed=0.
REQ-029 SETTLE=2, mul_p tied to 0, seed=0x00030005, num_samples=1 -> mul_a=3, mul_b=5, err_count=1, sum_abs_ed=15, max_abs_ed=15 (0 without MUL_ERR_MAX_TRACK_EN), done at cycle 5.
REQ-030 num_samples=0, start pulse -> done at cycle 1, busy never high, all metrics 0.
REQ-031 rst asserted in SETTLE of sample 2 of a 10-sample sweep -> next cycle IDLE, all outputs 0; a fresh start then completes normally.
REQ-032 start pulsed repeatedly during a busy sweep -> no restart; done timing and metrics identical to a single-start run; start coincident with rst -> remains IDLE.
REQ-033 Seed=0 against a model that returns the exact product minus 1 -> first operands come from LFSR 0x00000001 (mul_a=0, mul_b=1), and err_count counts every sample.

Source files
------------

// File: rtl/mul_err_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mul_err_sweep_ctrl
//  Purpose  : Error-characterisation sweep controller for a 16x16 multiplier
//             under test. A 32-bit Galois LFSR supplies operand pairs. For
//             each pair the controller drives the operands, waits SETTLE
//             cycles, then compares the returned product with the exact
//             product and accumulates error metrics.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    SETTLE       cycles allowed for mul_p to settle (1..1023)
//  Ports
//    clk          sole clock, rising edge
//    rst          synchronous active-high reset
//    start        single-cycle sweep request (accepted only in IDLE)
//    num_samples  number of operand pairs, sampled on accepted start
//    seed         LFSR seed, sampled on accepted start (0 loads as 1)
//    mul_a/mul_b  operands to the multiplier under test (registered)
//    mul_p        product returned by the multiplier under test
//    busy         high while a sweep is in progress
//    done         one-cycle pulse at sweep end
//    err_count    number of samples with mul_p != exact product
//    sum_abs_ed   sum of |exact - mul_p|
//    max_abs_ed   largest |exact - mul_p|
//  Configuration macro
//    MUL_ERR_MAX_TRACK_EN  defined   : max_abs_ed tracks the running maximum
//                          undefined : max tracker omitted, max_abs_ed = 0
// ============================================================================
module mul_err_sweep_ctrl #(
  parameter int unsigned SETTLE = 78
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] num_samples,
  input  logic [31:0] seed,
  output logic [15:0] mul_a,
  output logic [15:0] mul_b,
  input  logic [31:0] mul_p,
  output logic        busy,
  output logic        done,
  output logic [31:0] err_count,
  output logic [63:0] sum_abs_ed,
  output logic [31:0] max_abs_ed
);

  // Galois LFSR taps for x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] C_LFSR_MASK = 32'h8020_0003;
  localparam logic [31:0] C_LFSR_INIT = 32'h0000_0001;
  localparam int unsigned C_CNT_W     = 10;
  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(SETTLE - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t              state_q;
  logic [31:0]         n_q;
  logic [31:0]         idx_q;
  logic [31:0]         lfsr_q;
  logic [C_CNT_W-1:0]  cnt_q;
  logic [15:0]         mul_a_q;
  logic [15:0]         mul_b_q;
  logic                busy_q;
  logic                done_q;
  logic [31:0]         err_q;
  logic [63:0]         sum_q;

  // Combinational helpers used by the CHECK step
  logic [31:0] exact_d;
  logic [31:0] abs_diff_d;
  logic [31:0] lfsr_d;
  logic [31:0] idx_d;

  always_comb begin
    exact_d    = {16'd0, mul_a_q} * {16'd0, mul_b_q};
    abs_diff_d = (exact_d >= mul_p) ? (exact_d - mul_p) : (mul_p - exact_d);
    // Right-shifting Galois step: feed back the shifted-out bit via the mask
    lfsr_d     = lfsr_q[0] ? ((lfsr_q >> 1) ^ C_LFSR_MASK) : (lfsr_q >> 1);
    idx_d      = idx_q + 32'd1;
  end

  // --------------------------------------------------------------------------
  // Sweep FSM with registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      idx_q   <= '0;
      lfsr_q  <= C_LFSR_INIT;
      cnt_q   <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= '0;
      sum_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (start) begin
            n_q    <= num_samples;
            lfsr_q <= (seed == 32'd0) ? C_LFSR_INIT : seed;
            idx_q  <= '0;
            err_q  <= '0;
            sum_q  <= '0;
            if (num_samples == 32'd0) begin
              // Empty sweep: go straight to the done pulse, never busy
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_LOAD;
              busy_q  <= 1'b1;
            end
          end
        end

        ST_LOAD: begin
          mul_a_q <= lfsr_q[31:16];
          mul_b_q <= lfsr_q[15:0];
          cnt_q   <= '0;
          state_q <= ST_SETTLE;
        end

        ST_SETTLE: begin
          // Counter runs 0..SETTLE-1, giving exactly SETTLE cycles here
          if (cnt_q == C_CNT_LAST) begin
            state_q <= ST_CHECK;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_CHECK: begin
          if (exact_d != mul_p) begin
            err_q <= err_q + 32'd1;
          end
          sum_q  <= sum_q + {32'd0, abs_diff_d};
          lfsr_q <= lfsr_d;
          idx_q  <= idx_d;
          if (idx_d == n_q) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_LOAD;
          end
        end

        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Optional running-maximum tracker
  // --------------------------------------------------------------------------
`ifdef MUL_ERR_MAX_TRACK_EN
  logic [31:0] max_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      max_q <= '0;
    end else if ((state_q == ST_IDLE) && start) begin
      max_q <= '0;
    end else if ((state_q == ST_CHECK) && (abs_diff_d > max_q)) begin
      max_q <= abs_diff_d;
    end
  end

  assign max_abs_ed = max_q;
`else
  assign max_abs_ed = 32'd0;
`endif

  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err_count  = err_q;
  assign sum_abs_ed = sum_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_err_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mul_err_sweep_ctrl
//  Purpose  : Directed self-checking bench for mul_err_sweep_ctrl with
//             SETTLE=2 and a behavioural multiplier whose error mode is
//             selectable (exact, tied to zero, exact minus one).
//  Revision : 1.0  initial release
// ============================================================================
module tb_mul_err_sweep_ctrl;

  localparam int unsigned C_SETTLE = 2;
  localparam int          C_BUDGET = 500;
`ifdef MUL_ERR_MAX_TRACK_EN
  localparam bit C_MAXEN = 1'b1;
`else
  localparam bit C_MAXEN = 1'b0;
`endif

  localparam int C_MODE_EXACT  = 0;
  localparam int C_MODE_ZERO   = 1;
  localparam int C_MODE_MINUS1 = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] num_samples;
  logic [31:0] seed;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic [31:0] mul_p;
  logic        busy;
  logic        done;
  logic [31:0] err_count;
  logic [63:0] sum_abs_ed;
  logic [31:0] max_abs_ed;

  int mode;
  int n_tests = 0;
  int n_fail  = 0;

  int done_cyc;
  int busy_lo;
  int busy_hi;
  int busy_cnt;

  always #5 clk = ~clk;

  mul_err_sweep_ctrl #(.SETTLE(C_SETTLE)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_samples (num_samples),
    .seed        (seed),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_p       (mul_p),
    .busy        (busy),
    .done        (done),
    .err_count   (err_count),
    .sum_abs_ed  (sum_abs_ed),
    .max_abs_ed  (max_abs_ed)
  );

  // Behavioural multiplier under test
  logic [31:0] tb_exact;
  assign tb_exact = {16'd0, mul_a} * {16'd0, mul_b};

  always_comb begin
    mul_p = tb_exact;
    if (mode == C_MODE_ZERO) begin
      mul_p = 32'd0;
    end else if (mode == C_MODE_MINUS1) begin
      mul_p = tb_exact - 32'd1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one start, optionally hold start high for the whole sweep, and
  // record done/busy timing. Cycle 1 is the interval after the start edge.
  task automatic run_sweep(input logic [31:0] n, input logic [31:0] s, input bit hammer);
    done_cyc = -1;
    busy_lo  = -1;
    busy_hi  = -1;
    busy_cnt = 0;
    @(negedge clk);
    num_samples = n;
    seed        = s;
    start       = 1'b1;
    @(posedge clk);
    #1;
    if (!hammer) start = 1'b0;
    for (int c = 1; c <= C_BUDGET; c++) begin
      @(negedge clk);
      if (busy) begin
        if (busy_lo < 0) busy_lo = c;
        busy_hi = c;
        busy_cnt++;
      end
      if (done) begin
        done_cyc = c;
        break;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    num_samples = 32'd0;
    seed        = 32'd0;
    mode        = C_MODE_EXACT;

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_mul_a", 64'(mul_a), 64'd0);
    check("rst_mul_b", 64'(mul_b), 64'd0);
    check("rst_err", 64'(err_count), 64'd0);
    check("rst_sum", sum_abs_ed, 64'd0);
    check("rst_max", 64'(max_abs_ed), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // ---------------- exact multiplier, 3 samples ----------------
    mode = C_MODE_EXACT;
    run_sweep(32'd3, 32'h1234_5678, 1'b0);
    check("exact_done_cyc", 64'(done_cyc), 64'd13);
    check("exact_busy_lo", 64'(busy_lo), 64'd1);
    check("exact_busy_hi", 64'(busy_hi), 64'd12);
    check("exact_busy_cnt", 64'(busy_cnt), 64'd12);
    check("exact_err", 64'(err_count), 64'd0);
    check("exact_sum", sum_abs_ed, 64'd0);
    check("exact_max", 64'(max_abs_ed), 64'd0);
    check("exact_mul_a", 64'(mul_a), 64'h048D);
    check("exact_mul_b", 64'(mul_b), 64'h159E);
    @(negedge clk);
    check("exact_done_pulse", 64'(done), 64'd0);
    check("exact_busy_after", 64'(busy), 64'd0);

    // ---------------- product tied to zero, 1 sample ----------------
    mode = C_MODE_ZERO;
    run_sweep(32'd1, 32'h0003_0005, 1'b0);
    check("zero_done_cyc", 64'(done_cyc), 64'd5);
    check("zero_mul_a", 64'(mul_a), 64'd3);
    check("zero_mul_b", 64'(mul_b), 64'd5);
    check("zero_err", 64'(err_count), 64'd1);
    check("zero_sum", sum_abs_ed, 64'd15);
    check("zero_max", 64'(max_abs_ed), C_MAXEN ? 64'd15 : 64'd0);
    repeat (3) @(negedge clk);
    check("zero_hold_err", 64'(err_count), 64'd1);
    check("zero_hold_sum", sum_abs_ed, 64'd15);
    check("zero_hold_mul_a", 64'(mul_a), 64'd3);

    // ---------------- empty sweep clears metrics ----------------
    run_sweep(32'd0, 32'h0000_DEAD, 1'b0);
    check("empty_done_cyc", 64'(done_cyc), 64'd1);
    check("empty_busy_cnt", 64'(busy_cnt), 64'd0);
    check("empty_err", 64'(err_count), 64'd0);
    check("empty_sum", sum_abs_ed, 64'd0);
    check("empty_max", 64'(max_abs_ed), 64'd0);

    // ---------------- start held high during a 2-sample sweep ----------------
    mode = C_MODE_ZERO;
    run_sweep(32'd2, 32'h0003_0005, 1'b1);
    check("hammer_done_cyc", 64'(done_cyc), 64'd9);
    check("hammer_busy_cnt", 64'(busy_cnt), 64'd8);
    check("hammer_err", 64'(err_count), 64'd2);
    check("hammer_sum", sum_abs_ed, 64'h4011_0030);
    check("hammer_max", 64'(max_abs_ed), C_MAXEN ? 64'h4011_0021 : 64'd0);
    check("hammer_mul_a", 64'(mul_a), 64'h8021);
    check("hammer_mul_b", 64'(mul_b), 64'h8001);
    @(negedge clk);

    // ---------------- start coincident with reset ----------------
    num_samples = 32'd4;
    seed        = 32'h0003_0005;
    rst         = 1'b1;
    start       = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    check("rststart_busy", 64'(busy), 64'd0);
    check("rststart_done", 64'(done), 64'd0);
    repeat (2) @(negedge clk);
    check("rststart_idle_busy", 64'(busy), 64'd0);

    // ---------------- reset mid-sweep (SETTLE of sample 2) ----------------
    mode = C_MODE_ZERO;
    num_samples = 32'd10;
    seed        = 32'h0003_0005;
    start       = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(negedge clk);   // cycle 6: first SETTLE cycle of sample 2
    check("midrst_busy_pre", 64'(busy), 64'd1);
    check("midrst_err_pre", 64'(err_count), 64'd1);
    check("midrst_sum_pre", sum_abs_ed, 64'd15);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_mul_a", 64'(mul_a), 64'd0);
    check("midrst_mul_b", 64'(mul_b), 64'd0);
    check("midrst_err", 64'(err_count), 64'd0);
    check("midrst_sum", sum_abs_ed, 64'd0);
    check("midrst_max", 64'(max_abs_ed), 64'd0);
    repeat (3) @(negedge clk);
    check("midrst_stays_idle", 64'(busy), 64'd0);
    run_sweep(32'd1, 32'h0003_0005, 1'b0);
    check("midrst_fresh_done_cyc", 64'(done_cyc), 64'd5);
    check("midrst_fresh_err", 64'(err_count), 64'd1);
    check("midrst_fresh_sum", sum_abs_ed, 64'd15);

    // ---------------- zero seed, product off by one ----------------
    mode = C_MODE_MINUS1;
    run_sweep(32'd1, 32'd0, 1'b0);
    check("seed0_done_cyc", 64'(done_cyc), 64'd5);
    check("seed0_mul_a", 64'(mul_a), 64'd0);
    check("seed0_mul_b", 64'(mul_b), 64'd1);
    check("seed0_err", 64'(err_count), 64'd1);
    check("seed0_sum", sum_abs_ed, 64'hFFFF_FFFF);
    run_sweep(32'd3, 32'd0, 1'b0);
    check("seed0x3_done_cyc", 64'(done_cyc), 64'd13);
    check("seed0x3_err", 64'(err_count), 64'd3);
    check("seed0x3_sum", sum_abs_ed, 64'h1_0000_0001);
    check("seed0x3_max", 64'(max_abs_ed), C_MAXEN ? 64'hFFFF_FFFF : 64'd0);
    check("seed0x3_mul_a", 64'(mul_a), 64'hC030);
    check("seed0x3_mul_b", 64'(mul_b), 64'h0002);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
